// File: rtl/ram_2port_window.sv
// Single-clock true dual-port RAM. Each read returns NTAPS consecutive words starting at the address.
// Define RAM_WINDOW_OUTREG_EN to add an output register stage, which makes read latency 2 cycles.
module ram_2port_window #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 9,
    parameter int NTAPS  = 2,
    parameter int WRAP   = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      ena,
    input  logic                      wea,
    input  logic [AWIDTH-1:0]         addra,
    input  logic [DWIDTH-1:0]         dia,
    output logic [NTAPS*DWIDTH-1:0]   doa,
    output logic                      doa_vld,
    input  logic                      enb,
    input  logic                      web,
    input  logic [AWIDTH-1:0]         addrb,
    input  logic [DWIDTH-1:0]         dib,
    output logic [NTAPS*DWIDTH-1:0]   dob,
    output logic                      dob_vld,
    output logic                      collision
);

    localparam int DEPTH = 1 << AWIDTH;

    logic [DWIDTH-1:0]       r_mem [DEPTH];
    logic [NTAPS*DWIDTH-1:0] w_win_a;
    logic [NTAPS*DWIDTH-1:0] w_win_b;
    logic                    w_wr_a;
    logic                    w_wr_b;

    assign w_wr_a = ena & wea;
    assign w_wr_b = enb & web;

    // Port B is written last so that it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (w_wr_a) r_mem[addra] <= dia;
        if (w_wr_b) r_mem[addrb] <= dib;
    end

    for (genvar k = 0; k < NTAPS; k++) begin : g_tap
        logic [AWIDTH:0] w_ext_a;
        logic [AWIDTH:0] w_ext_b;

        assign w_ext_a = {1'b0, addra} + (AWIDTH+1)'(k);
        assign w_ext_b = {1'b0, addrb} + (AWIDTH+1)'(k);

        if (WRAP != 0) begin : g_wrap
            assign w_win_a[k*DWIDTH +: DWIDTH] = r_mem[w_ext_a[AWIDTH-1:0]];
            assign w_win_b[k*DWIDTH +: DWIDTH] = r_mem[w_ext_b[AWIDTH-1:0]];
        end else begin : g_zero
            assign w_win_a[k*DWIDTH +: DWIDTH] = w_ext_a[AWIDTH] ? '0 : r_mem[w_ext_a[AWIDTH-1:0]];
            assign w_win_b[k*DWIDTH +: DWIDTH] = w_ext_b[AWIDTH] ? '0 : r_mem[w_ext_b[AWIDTH-1:0]];
        end
    end

    logic [NTAPS*DWIDTH-1:0] r_doa_s1;
    logic [NTAPS*DWIDTH-1:0] r_dob_s1;
    logic                    r_doa_vld_s1;
    logic                    r_dob_vld_s1;
    logic                    r_collision;

    // The memory is sampled before this edge's writes land, which makes reads read-first on both ports.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_doa_s1     <= '0;
            r_dob_s1     <= '0;
            r_doa_vld_s1 <= 1'b0;
            r_dob_vld_s1 <= 1'b0;
            r_collision  <= 1'b0;
        end else begin
            r_doa_vld_s1 <= ena;
            r_dob_vld_s1 <= enb;
            if (ena) r_doa_s1 <= w_win_a;
            if (enb) r_dob_s1 <= w_win_b;
            r_collision  <= w_wr_a & w_wr_b & (addra == addrb);
        end
    end

    assign collision = r_collision;

`ifdef RAM_WINDOW_OUTREG_EN
    logic [NTAPS*DWIDTH-1:0] r_doa_s2;
    logic [NTAPS*DWIDTH-1:0] r_dob_s2;
    logic                    r_doa_vld_s2;
    logic                    r_dob_vld_s2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_doa_s2     <= '0;
            r_dob_s2     <= '0;
            r_doa_vld_s2 <= 1'b0;
            r_dob_vld_s2 <= 1'b0;
        end else begin
            r_doa_s2     <= r_doa_s1;
            r_dob_s2     <= r_dob_s1;
            r_doa_vld_s2 <= r_doa_vld_s1;
            r_dob_vld_s2 <= r_dob_vld_s1;
        end
    end

    assign doa     = r_doa_s2;
    assign dob     = r_dob_s2;
    assign doa_vld = r_doa_vld_s2;
    assign dob_vld = r_dob_vld_s2;
`else
    assign doa     = r_doa_s1;
    assign dob     = r_dob_s1;
    assign doa_vld = r_doa_vld_s1;
    assign dob_vld = r_dob_vld_s1;
`endif

endmodule

// File: tb/tb_ram_2port_window.sv
// Bench for ram_2port_window: a wrapping and a zero-fill instance share stimulus and are checked against an array model.
// Honours RAM_WINDOW_OUTREG_EN for the expected read latency.
module tb_ram_2port_window;

`ifdef RAM_WINDOW_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        ena = 1'b0, wea = 1'b0, enb = 1'b0, web = 1'b0;
    logic [3:0]  addra = '0, addrb = '0;
    logic [15:0] dia = '0, dib = '0;
    logic [63:0] doa1, dob1, doa0, dob0;
    logic        doa_vld1, dob_vld1, col1, doa_vld0, dob_vld0, col0;

    int checks = 0;
    int errors = 0;
    logic [15:0] model [16];

    always #5 clk = ~clk;

    ram_2port_window #(.DWIDTH(16), .AWIDTH(4), .NTAPS(4), .WRAP(1)) dut_w (
        .clk(clk), .reset_n(reset_n),
        .ena(ena), .wea(wea), .addra(addra), .dia(dia), .doa(doa1), .doa_vld(doa_vld1),
        .enb(enb), .web(web), .addrb(addrb), .dib(dib), .dob(dob1), .dob_vld(dob_vld1),
        .collision(col1)
    );

    ram_2port_window #(.DWIDTH(16), .AWIDTH(4), .NTAPS(4), .WRAP(0)) dut_z (
        .clk(clk), .reset_n(reset_n),
        .ena(ena), .wea(wea), .addra(addra), .dia(dia), .doa(doa0), .doa_vld(doa_vld0),
        .enb(enb), .web(web), .addrb(addrb), .dib(dib), .dob(dob0), .dob_vld(dob_vld0),
        .collision(col0)
    );

    typedef struct {
        logic        va, vb;
        logic [63:0] a1, b1, a0, b0;
    } exp_t;

    function automatic logic [63:0] exp_win(input int addr, input bit wrap);
        logic [63:0] w;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            int a;
            a = addr + k;
            if (a < 16) w[k*16 +: 16] = model[a];
            else if (wrap) w[k*16 +: 16] = model[a - 16];
        end
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (LAT - 1) tick();
    endtask

    task automatic drive(input logic ea, input logic wa, input logic [3:0] aa, input logic [15:0] da,
                         input logic eb, input logic wb, input logic [3:0] ab, input logic [15:0] db);
        ena = ea; wea = wa; addra = aa; dia = da;
        enb = eb; web = wb; addrb = ab; dib = db;
        if (ea && wa) model[aa] = da;
        if (eb && wb) model[ab] = db;
        tick();
        ena = 1'b0; enb = 1'b0; wea = 1'b0; web = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (doa1 !== '0 || dob1 !== '0 || doa0 !== '0 || dob0 !== '0) begin
            errors++; $display("FAIL reset_data got %h %h %h %h want 0", doa1, dob1, doa0, dob0);
        end
        checks++;
        if ({doa_vld1, dob_vld1, doa_vld0, dob_vld0, col1, col0} !== 6'b0) begin
            errors++; $display("FAIL reset_flags got %b want 000000", {doa_vld1, dob_vld1, doa_vld0, dob_vld0, col1, col0});
        end
        tick(); tick();
        reset_n = 1'b1;
    endtask

    task automatic test_fill_window();
        int n;
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b1, 4'(i), 16'(i + 'h100), 1'b0, 1'b0, 4'd0, 16'd0);
        repeat (LAT + 1) tick();
        ena = 1'b1; addra = 4'd14;
        tick();
        ena = 1'b0;
        n = 1;
        while (!doa_vld1 && n < 6) begin tick(); n++; end
        checks++;
        if (n != LAT) begin errors++; $display("FAIL fill_latency got %0d want %0d", n, LAT); end
        checks++;
        if (doa1 !== 64'h0101_0100_010F_010E || doa_vld1 !== 1'b1) begin
            errors++; $display("FAIL fill_wrap got %h vld %b want 0101010001 0f010e vld 1", doa1, doa_vld1);
        end
        checks++;
        if (doa0 !== 64'h0000_0000_010F_010E || doa_vld0 !== 1'b1) begin
            errors++; $display("FAIL fill_zero got %h vld %b want 00000000010f010e vld 1", doa0, doa_vld0);
        end
        tick();
        checks++;
        if (doa_vld1 !== 1'b0) begin errors++; $display("FAIL vld_pulse got %b want 0", doa_vld1); end
    endtask

    task automatic test_read_first();
        drive(1'b1, 1'b1, 4'd5, 16'hAAAA, 1'b0, 1'b0, 4'd0, 16'd0);
        drive(1'b1, 1'b1, 4'd5, 16'h5555, 1'b1, 1'b0, 4'd4, 16'd0);
        settle();
        checks++;
        if (doa1[15:0] !== 16'hAAAA) begin errors++; $display("FAIL rf_same got %h want aaaa", doa1[15:0]); end
        checks++;
        if (dob1[31:16] !== 16'hAAAA || dob_vld1 !== 1'b1) begin
            errors++; $display("FAIL rf_cross got %h vld %b want aaaa vld 1", dob1[31:16], dob_vld1);
        end
        drive(1'b1, 1'b0, 4'd5, 16'd0, 1'b1, 1'b0, 4'd5, 16'd0);
        settle();
        checks++;
        if (doa1[15:0] !== 16'h5555 || dob1[15:0] !== 16'h5555) begin
            errors++; $display("FAIL rf_after got %h %h want 5555", doa1[15:0], dob1[15:0]);
        end
    endtask

    task automatic test_collision();
        drive(1'b1, 1'b1, 4'd7, 16'h1111, 1'b1, 1'b1, 4'd7, 16'h2222);
        checks++;
        if (col1 !== 1'b1 || col0 !== 1'b1) begin errors++; $display("FAIL col_pulse got %b%b want 11", col1, col0); end
        tick();
        checks++;
        if (col1 !== 1'b0) begin errors++; $display("FAIL col_width got %b want 0", col1); end
        drive(1'b1, 1'b0, 4'd7, 16'd0, 1'b0, 1'b0, 4'd0, 16'd0);
        settle();
        checks++;
        if (doa1[15:0] !== 16'h2222) begin errors++; $display("FAIL col_data got %h want 2222", doa1[15:0]); end
        drive(1'b1, 1'b1, 4'd7, 16'h3333, 1'b1, 1'b1, 4'd8, 16'h4444);
        checks++;
        if (col1 !== 1'b0) begin errors++; $display("FAIL col_diff got %b want 0", col1); end
        drive(1'b1, 1'b0, 4'd7, 16'd0, 1'b0, 1'b0, 4'd0, 16'd0);
        settle();
        checks++;
        if (doa1[31:0] !== 32'h4444_3333) begin errors++; $display("FAIL col_both got %h want 44443333", doa1[31:0]); end
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t e, g;
        logic [63:0] ha1, hb1, ha0, hb0;
        logic ecol;
        ha1 = '0; hb1 = '0; ha0 = '0; hb0 = '0;
        for (int c = 0; c < 400; c++) begin
            ena = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            enb = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            wea = 1'($urandom_range(0, 1));
            web = 1'($urandom_range(0, 1));
            addra = 4'($urandom_range(0, 15));
            addrb = ($urandom_range(0, 3) == 0) ? addra : 4'($urandom_range(0, 15));
            dia = 16'($urandom);
            dib = 16'($urandom);
            if (ena) begin ha1 = exp_win(int'(addra), 1'b1); ha0 = exp_win(int'(addra), 1'b0); end
            if (enb) begin hb1 = exp_win(int'(addrb), 1'b1); hb0 = exp_win(int'(addrb), 1'b0); end
            e.va = ena; e.vb = enb; e.a1 = ha1; e.b1 = hb1; e.a0 = ha0; e.b0 = hb0;
            ecol = ena && wea && enb && web && (addra == addrb);
            if (ena && wea) model[addra] = dia;
            if (enb && web) model[addrb] = dib;
            q.push_back(e);
            tick();
            checks++;
            if (col1 !== ecol || col0 !== ecol) begin
                errors++; $display("FAIL rnd_col cyc %0d got %b%b want %b", c, col1, col0, ecol);
            end
            if (q.size() == LAT) begin
                g = q.pop_front();
                checks++;
                if ({doa_vld1, dob_vld1, doa_vld0, dob_vld0} !== {g.va, g.vb, g.va, g.vb}) begin
                    errors++; $display("FAIL rnd_vld cyc %0d got %b%b%b%b want %b%b", c, doa_vld1, dob_vld1, doa_vld0, dob_vld0, g.va, g.vb);
                end
                checks++;
                if (doa1 !== g.a1 || dob1 !== g.b1 || doa0 !== g.a0 || dob0 !== g.b0) begin
                    errors++; $display("FAIL rnd_data cyc %0d got %h %h %h %h want %h %h %h %h", c, doa1, dob1, doa0, dob0, g.a1, g.b1, g.a0, g.b0);
                end
            end
        end
        ena = 1'b0; enb = 1'b0; wea = 1'b0; web = 1'b0;
        repeat (LAT + 1) tick();
    endtask

    task automatic test_reset_midstream();
        int n;
        ena = 1'b1; wea = 1'b0; addra = 4'd3;
        repeat (3) tick();
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if (doa1 !== '0 || doa_vld1 !== 1'b0 || col1 !== 1'b0 || dob1 !== '0) begin
            errors++; $display("FAIL mid_reset got %h vld %b col %b want 0", doa1, doa_vld1, col1);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        n = 0;
        while (n < 8) begin
            tick(); n++;
            if (doa_vld1) break;
        end
        checks++;
        if (n != LAT) begin errors++; $display("FAIL mid_latency got %0d want %0d", n, LAT); end
        checks++;
        if (doa1 !== exp_win(3, 1'b1)) begin errors++; $display("FAIL mid_data got %h want %h", doa1, exp_win(3, 1'b1)); end
        ena = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_fill_window();
        test_read_first();
        test_collision();
        test_random();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_2port_window.md
# ram_2port_window

Single-clock true dual-port RAM in which each read returns a window of NTAPS consecutive words starting at the addressed word, not just the addressed word and its successor. Each port has its own read-valid strobe, the wrap policy at the top of memory is selectable, same-address write collisions resolve deterministically and are flagged, and an optional output register stage can be compiled in. It serves the gmrr datapath wherever interpolators and filters need several adjacent samples per access.

## Interface
- DWIDTH, default 32: word width in bits.
- AWIDTH, default 9: address width; depth is 2^AWIDTH words.
- NTAPS, default 2: words returned per read, legal range 1..8.
- WRAP, default 1: 1 means window addresses wrap modulo depth; 0 means taps past the last word read as zero.

Ports:
- clk  in  1: sole clock, rising edge.
- reset_n  in  1: asynchronous, active-low reset.
- ena  in  1: port A access enable.
- wea  in  1: port A write enable, qualified by ena.
- addra  in  AWIDTH: port A address.
- dia  in  DWIDTH: port A write data.
- doa  out  NTAPS*DWIDTH: port A window; tap k occupies bits [k*DWIDTH +: DWIDTH] and holds word addra+k.
- doa_vld  out  1: doa updated this cycle.
- enb, web, addrb, dib, dob, dob_vld: port B equivalents of the port A signals.
- collision  out  1: one-cycle pulse when both ports wrote the same address in the same cycle.

## Operation
- Memory contents are not reset and are undefined after power-up. Only the output and pipeline registers are reset.
- On reset assertion, doa, dob, doa_vld, dob_vld and collision clear to 0 immediately. In-flight reads are discarded.
- Read (en=1, any we): captures ram[addr+k] for k=0..NTAPS-1.
- Address arithmetic is AWIDTH bits wide.
  - WRAP=1: addr+k is taken modulo 2^AWIDTH.
  - WRAP=0: any tap whose un-truncated addr+k is at least 2^AWIDTH returns 0.
- Read-during-write on the same port is read-first: the window shows the pre-write contents.
- A read that hits an address the other port writes in the same cycle also returns the old data, on every tap.
- Write collision: if both ports write the same address in the same cycle, port B's data is stored and collision pulses on the next cycle.
- If the ports write different addresses in the same cycle, both writes complete.
- When en=0, the port's outputs hold their last value and its vld is 0.
- The *_vld strobe tracks en, not we; a write access still produces a valid read-first window.

## Timing
- Base latency is 1 cycle: inputs are sampled at edge N, and the window and vld appear after edge N.
- With RAM_WINDOW_OUTREG_EN defined, latency is 2 cycles. The window and vld then appear after edge N+1.
- The ports are fully pipelined: one access per port per cycle with no stalls.
- vld is a single-cycle pulse per access. Back-to-back accesses give continuous vld.
- Written data is visible to either port on an access issued one cycle after the write.
- collision is registered and aligned to base latency 1 whether or not the macro is defined.
- reset_n deassertion must be synchronous to clk (the integrating design provides the synchronizer). The first access is accepted on the first edge after deassertion.

## Configuration
- RAM_WINDOW_OUTREG_EN:
  - Defined: an extra register stage follows the window mux on both ports, covering data and vld. Read latency is 2. These registers are also cleared by reset_n.
  - Undefined: latency is 1 and there are no extra registers.
- Collision timing and memory behaviour are identical in both builds.

## Test plan
- Reset mid-stream: drive ena=1 every cycle, then pulse reset_n low between edges. doa, doa_vld and collision must read 0 immediately. After release, the first access returns vld one latency later.
- Fill and window read, with WRAP=1, NTAPS=4, AWIDTH=4: write ram[i]=i+0x100 for i=0..15, then read addr 14. doa must be {0x101,0x100,0x10F,0x10E} (tap3..tap0), with doa_vld high.
- Zero-fill at the top, with WRAP=0 and the same contents: read addr 14. Taps 0 and 1 must be 0x10E and 0x10F; taps 2 and 3 must be 0.
- Read-first:
  - Same port: with ram[5]=0xAAAA, issue wea=1, addra=5, dia=0x5555. doa tap0 must be 0xAAAA.
  - Cross port: in the same cycle, port B reads addr 4. dob tap1 must be 0xAAAA.
  - Next cycle: a read of addr 5 must return 0x5555.
- Collision: both ports write addr 7 in the same cycle, A with 0x1111 and B with 0x2222. collision must pulse exactly one cycle, and a later read of addr 7 must return 0x2222. A write of addr 7 by A and addr 8 by B must not pulse collision.
- Latency check: run the fill-and-window case both with and without RAM_WINDOW_OUTREG_EN. The vld edge must occur 1 and 2 cycles after the en edge respectively, with identical data.
